// File: rtl/mpu_store_stream.sv
// mpu_store_stream: reads a matrix from the register file one element at a
// time and streams it to memory as valid/ready beats, flagging the last beat.
// Optional build macro MPU_STORE_TRANSPOSE_EN adds col_major_in, which selects
// column-major streaming order per request; without it the order is row-major.
module mpu_store_stream #(
   parameter int DATA_W = 32,
   parameter int MAX_M  = 8,
   parameter int MAX_N  = 8,
   parameter int ADDR_W = 3,
   localparam int MW    = $clog2(MAX_M + 1),
   localparam int NW    = $clog2(MAX_N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              store_req_in,
   input  logic [ADDR_W-1:0] store_addr_in,
`ifdef MPU_STORE_TRANSPOSE_EN
   input  logic              col_major_in,
`endif
   input  logic              reg_ready_in,
   input  logic [MW-1:0]     reg_m_size_in,
   input  logic [NW-1:0]     reg_n_size_in,
   input  logic [DATA_W-1:0] reg_element_in,
   output logic              reg_req_out,
   output logic [ADDR_W-1:0] reg_addr_out,
   output logic [MW-1:0]     reg_i_out,
   output logic [NW-1:0]     reg_j_out,
   output logic              mem_valid_out,
   input  logic              mem_ready_in,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_last_out,
   output logic [MW-1:0]     mem_m_size_out,
   output logic [NW-1:0]     mem_n_size_out,
   output logic              busy_out,
   output logic              done_out,
   output logic              err_out
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQUEST = 2'd1;
   localparam logic [1:0] ST_STREAM  = 2'd2;

   localparam logic [MW-1:0] MAX_M_V = MW'(MAX_M);
   localparam logic [NW-1:0] MAX_N_V = NW'(MAX_N);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [MW-1:0]     r_m;
   logic [NW-1:0]     r_n;
   logic [MW-1:0]     r_i;
   logic [NW-1:0]     r_j;
   logic              r_done;
   logic              r_err;

   logic              w_stream;
   logic              w_hs;
   logic [MW-1:0]     w_m_last;
   logic [NW-1:0]     w_n_last;
   logic              w_i_end;
   logic              w_j_end;
   logic              w_last;
   logic              w_size_bad;
   logic              w_col;

`ifdef MPU_STORE_TRANSPOSE_EN
   logic r_col;

   // Capture the order select together with the accepted request.
   always_ff @(posedge clk) begin
      if (rst)
         r_col <= 1'b0;
      else if (r_state == ST_IDLE && store_req_in)
         r_col <= col_major_in;
   end

   assign w_col = r_col;
`else
   assign w_col = 1'b0;
`endif

   assign w_stream   = (r_state == ST_STREAM);
   assign w_hs       = w_stream & mem_ready_in;
   assign w_m_last   = r_m - 1'b1;
   assign w_n_last   = r_n - 1'b1;
   assign w_i_end    = (r_i == w_m_last);
   assign w_j_end    = (r_j == w_n_last);
   assign w_last     = w_i_end & w_j_end;
   assign w_size_bad = (reg_m_size_in == '0) | (reg_n_size_in == '0) |
                       (reg_m_size_in > MAX_M_V) | (reg_n_size_in > MAX_N_V);

   // Control FSM, latched request context and element index walk.
   // NOTE: every register here is written with <= so all of them update from
   // the same pre-edge values; a blocking = would leak new values mid-block.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_m     <= '0;
         r_n     <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (store_req_in) begin
                  r_addr  <= store_addr_in;
                  r_state <= ST_REQUEST;
               end
            end
            ST_REQUEST: begin
               if (reg_ready_in) begin
                  r_m <= reg_m_size_in;
                  r_n <= reg_n_size_in;
                  r_i <= '0;
                  r_j <= '0;
                  if (w_size_bad) begin
                     r_err   <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_i     <= '0;
                     r_j     <= '0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else if (w_col) begin
                     if (w_i_end) begin
                        r_i <= '0;
                        r_j <= r_j + 1'b1;
                     end else begin
                        r_i <= r_i + 1'b1;
                     end
                  end else begin
                     if (w_j_end) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                     end else begin
                        r_j <= r_j + 1'b1;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign reg_req_out    = w_stream;
   assign reg_addr_out   = r_addr;
   assign reg_i_out      = r_i;
   assign reg_j_out      = r_j;
   assign mem_valid_out  = w_stream;
   assign mem_data_out   = w_stream ? reg_element_in : '0;
   assign mem_last_out   = w_stream & w_last;
   assign mem_m_size_out = r_m;
   assign mem_n_size_out = r_n;
   assign busy_out       = (r_state != ST_IDLE);
   assign done_out       = r_done;
   assign err_out        = r_err;

endmodule

// File: tb/tb_mpu_store_stream.sv
// Directed bench for mpu_store_stream with a beat scoreboard and a simple
// register-file model driving reg_element_in from the requested indices.
module tb_mpu_store_stream;

   localparam int DW = 32;
   localparam int MW = 4;
   localparam int NW = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          store_req_in;
   logic [AW-1:0] store_addr_in;
`ifdef MPU_STORE_TRANSPOSE_EN
   logic          col_major_in;
`endif
   logic          reg_ready_in;
   logic [MW-1:0] reg_m_size_in;
   logic [NW-1:0] reg_n_size_in;
   logic [DW-1:0] reg_element_in;
   logic          reg_req_out;
   logic [AW-1:0] reg_addr_out;
   logic [MW-1:0] reg_i_out;
   logic [NW-1:0] reg_j_out;
   logic          mem_valid_out;
   logic          mem_ready_in;
   logic [DW-1:0] mem_data_out;
   logic          mem_last_out;
   logic [MW-1:0] mem_m_size_out;
   logic [NW-1:0] mem_n_size_out;
   logic          busy_out;
   logic          done_out;
   logic          err_out;

   always #5 clk = ~clk;

   mpu_store_stream dut (
      .clk            (clk),
      .rst            (rst),
      .store_req_in   (store_req_in),
      .store_addr_in  (store_addr_in),
`ifdef MPU_STORE_TRANSPOSE_EN
      .col_major_in   (col_major_in),
`endif
      .reg_ready_in   (reg_ready_in),
      .reg_m_size_in  (reg_m_size_in),
      .reg_n_size_in  (reg_n_size_in),
      .reg_element_in (reg_element_in),
      .reg_req_out    (reg_req_out),
      .reg_addr_out   (reg_addr_out),
      .reg_i_out      (reg_i_out),
      .reg_j_out      (reg_j_out),
      .mem_valid_out  (mem_valid_out),
      .mem_ready_in   (mem_ready_in),
      .mem_data_out   (mem_data_out),
      .mem_last_out   (mem_last_out),
      .mem_m_size_out (mem_m_size_out),
      .mem_n_size_out (mem_n_size_out),
      .busy_out       (busy_out),
      .done_out       (done_out),
      .err_out        (err_out)
   );

   // Register file content: a unique word per (register, row, column).
   function automatic logic [DW-1:0] elem(input logic [AW-1:0] a, input logic [MW-1:0] i,
                                          input logic [NW-1:0] j);
      return {8'hC3, 5'd0, a, 4'd0, i, 4'd0, j};
   endfunction

   assign reg_element_in = elem(reg_addr_out, reg_i_out, reg_j_out);

   typedef struct packed {
      logic [MW-1:0] i;
      logic [NW-1:0] j;
      logic [DW-1:0] d;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   int    vectors     = 0;
   int    miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, mem_valid_out, 0);
      check({tag, "_reg_req"}, reg_req_out, 0);
      check({tag, "_last"}, mem_last_out, 0);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_done"}, done_out, 0);
      check({tag, "_err"}, err_out, 0);
      check({tag, "_i"}, reg_i_out, 0);
      check({tag, "_j"}, reg_j_out, 0);
      check({tag, "_msize"}, mem_m_size_out, 0);
      check({tag, "_nsize"}, mem_n_size_out, 0);
      check({tag, "_addr"}, reg_addr_out, 0);
      check({tag, "_data"}, mem_data_out, 0);
   endtask

   // One store request; stall_beat/stall_cyc hold ready low while that beat
   // (0-based) is presented; abort_at asserts rst while that beat is presented;
   // poke re-asserts store_req_in mid-stream, which must be ignored.
   task automatic do_store(input logic [AW-1:0] addr, input int m, input int n, input bit col,
                           input int req_delay, input int stall_beat, input int stall_cyc,
                           input int abort_at, input bit poke);
      int    total   = m * n;
      int    b       = 0;
      int    stalled = 0;
      beat_t bt;
      exp_q.delete();
      if (col) begin
         for (int jj = 0; jj < n; jj++)
            for (int ii = 0; ii < m; ii++) begin
               bt.i = ii[MW-1:0]; bt.j = jj[NW-1:0];
               bt.d = elem(addr, bt.i, bt.j);
               bt.last = (ii == m - 1) && (jj == n - 1);
               exp_q.push_back(bt);
            end
      end else begin
         for (int ii = 0; ii < m; ii++)
            for (int jj = 0; jj < n; jj++) begin
               bt.i = ii[MW-1:0]; bt.j = jj[NW-1:0];
               bt.d = elem(addr, bt.i, bt.j);
               bt.last = (ii == m - 1) && (jj == n - 1);
               exp_q.push_back(bt);
            end
      end

      @(posedge clk); #1;
      store_req_in  = 1'b1;
      store_addr_in = addr;
`ifdef MPU_STORE_TRANSPOSE_EN
      col_major_in  = col;
`endif
      reg_m_size_in = m[MW-1:0];
      reg_n_size_in = n[NW-1:0];
      reg_ready_in  = 1'b0;
      mem_ready_in  = 1'b1;
      @(posedge clk); #1;
      store_req_in = 1'b0;
      for (int k = 0; k < req_delay; k++) begin
         @(negedge clk);
         check("busy_request", busy_out, 1);
         check("valid_request", mem_valid_out, 0);
         @(posedge clk); #1;
      end
      reg_ready_in = 1'b1;

      for (int cyc = 0; cyc < 400 && b < total; cyc++) begin
         @(posedge clk); #1;
         reg_ready_in = 1'b0;
         if (b == abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_all_zero("abort");
            @(posedge clk);
            @(negedge clk);
            check("abort_no_done", done_out, 0);
            check("abort_idle", busy_out, 0);
            exp_q.delete();
            return;
         end
         if (poke && cyc == 1) begin
            store_req_in  = 1'b1;
            store_addr_in = ~addr;
         end else begin
            store_req_in = 1'b0;
         end
         if (b == stall_beat && stalled < stall_cyc) begin
            mem_ready_in = 1'b0;
            stalled++;
         end else begin
            mem_ready_in = 1'b1;
         end
         @(negedge clk);
         check("valid", mem_valid_out, 1);
         check("reg_req", reg_req_out, 1);
         check("busy_stream", busy_out, 1);
         check("done_in_stream", done_out, 0);
         check("i", reg_i_out, exp_q[0].i);
         check("j", reg_j_out, exp_q[0].j);
         check("data", mem_data_out, exp_q[0].d);
         check("last", mem_last_out, exp_q[0].last);
         if (mem_ready_in) begin
            void'(exp_q.pop_front());
            b++;
         end
      end
      store_req_in = 1'b0;
      check("beat_count", b, total);
      check("stall_cycles", stalled, stall_cyc);
      if (b < total) begin
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         exp_q.delete();
         return;
      end
      @(posedge clk); #1;
      mem_ready_in = 1'b0;
      @(negedge clk);
      check("done_pulse", done_out, 1);
      check("valid_after", mem_valid_out, 0);
      check("busy_after", busy_out, 0);
      check("i_after", reg_i_out, 0);
      check("j_after", reg_j_out, 0);
      check("msize_latched", mem_m_size_out, m);
      check("nsize_latched", mem_n_size_out, n);
      check("addr_latched", reg_addr_out, addr);
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", done_out, 0);
      check("still_idle", busy_out, 0);
   endtask

   // Request with illegal sizes: one-cycle err_out, no beats, back to IDLE.
   task automatic do_err(input int m, input int n);
      @(posedge clk); #1;
      store_req_in  = 1'b1;
      store_addr_in = 3'd2;
      reg_m_size_in = m[MW-1:0];
      reg_n_size_in = n[NW-1:0];
      @(posedge clk); #1;
      store_req_in = 1'b0;
      reg_ready_in = 1'b1;
      @(posedge clk); #1;
      reg_ready_in = 1'b0;
      @(negedge clk);
      check("err_pulse", err_out, 1);
      check("err_valid", mem_valid_out, 0);
      check("err_busy", busy_out, 0);
      check("err_done", done_out, 0);
      @(posedge clk);
      @(negedge clk);
      check("err_one_cycle", err_out, 0);
      check("err_valid2", mem_valid_out, 0);
   endtask

   initial begin
      rst           = 1'b1;
      store_req_in  = 1'b0;
      store_addr_in = '0;
`ifdef MPU_STORE_TRANSPOSE_EN
      col_major_in  = 1'b0;
`endif
      reg_ready_in  = 1'b0;
      reg_m_size_in = '0;
      reg_n_size_in = '0;
      mem_ready_in  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // 2x3 with ready always high: six consecutive beats.
      do_store(3'd3, 2, 3, 1'b0, 0, -1, 0, -1, 1'b0);
      // 2x3 with ready low 3 cycles on the second beat, plus an ignored request.
      do_store(3'd5, 2, 3, 1'b0, 0, 1, 3, -1, 1'b1);
      // Illegal sizes.
      do_err(0, 3);
      do_err(2, 9);
      do_err(3, 0);
      do_err(9, 2);
`ifdef MPU_STORE_TRANSPOSE_EN
      do_store(3'd6, 2, 3, 1'b1, 0, -1, 0, -1, 1'b0);
      do_store(3'd1, 3, 2, 1'b1, 1, 2, 2, -1, 1'b0);
`endif
      // Reset mid-stream at beat 3 of 4x4, then a complete 4x4.
      do_store(3'd4, 4, 4, 1'b0, 0, -1, 0, 2, 1'b0);
      do_store(3'd4, 4, 4, 1'b0, 0, -1, 0, -1, 1'b0);
      // 1x1 with the register grant delayed 4 cycles.
      do_store(3'd2, 1, 1, 1'b0, 4, -1, 0, -1, 1'b0);
      // Largest legal matrix with a stall on the final beat.
      do_store(3'd7, 8, 8, 1'b0, 0, 63, 2, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
